receptor_pacote: RTL

- Serial receiver for the 11-bit address+data packet, pacote = {endereco[2:0], dados[7:0]}.
- Deserializes a framed bit stream and checks the stop bit.
- Filters on a local address and presents dados/endereco/pacote with a one-cycle valido pulse.
- Sits at the far end of the packet serial link, feeding the local data consumer.

---
 rtl/receptor_pacote.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/receptor_pacote.sv
// Serial receiver for {endereco, dados} frames with stop-bit check and local address filter.
// valido/descartado/erro_quadro pulse one cycle after the stop-bit sample; no backpressure.
module receptor_pacote #(
    parameter int         CICLOS_POR_BIT     = 4,
    parameter logic [2:0] ENDERECO_BROADCAST = 3'b111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        serial_in,
    input  logic [2:0]  meu_endereco,
    input  logic        aceita_broadcast,
    output logic [7:0]  dados,
    output logic [2:0]  endereco,
    output logic [10:0] pacote,
    output logic        valido,
    output logic        erro_quadro,
    output logic        descartado,
    output logic        ocupado
);

    localparam int             CW       = $clog2(CICLOS_POR_BIT);
    localparam logic [CW-1:0]  CNT_BIT  = CW'(CICLOS_POR_BIT - 1);
    localparam logic [CW-1:0]  CNT_MEIO = CW'(CICLOS_POR_BIT / 2 - 1);

    typedef enum logic [2:0] {
        OCIOSO,
        INICIO,
        DADOS,
        PARADA,
        ESPERA
    } estado_t;

    estado_t        state_q, state_d;
    logic           sync_q, rx_s_q;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     idx_q, idx_d;
    logic [10:0]    shift_q, shift_d;
    logic [10:0]    pacote_q, pacote_d;
    logic           valido_q, valido_d;
    logic           erro_q, erro_d;
    logic           desc_q, desc_d;
    logic           end_ok;

    assign end_ok = (shift_q[10:8] == meu_endereco) ||
                    (aceita_broadcast && (shift_q[10:8] == ENDERECO_BROADCAST));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        pacote_d = pacote_q;
        valido_d = 1'b0;
        erro_d   = 1'b0;
        desc_d   = 1'b0;
        case (state_q)
            OCIOSO: begin
                if (!rx_s_q) begin
                    state_d = INICIO;
                    cnt_d   = '0;
                end
            end
            INICIO: begin
                if (cnt_q == CNT_MEIO) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // A start bit that is already gone at mid-bit was a glitch.
                    state_d = rx_s_q ? OCIOSO : DADOS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DADOS: begin
                if (cnt_q == CNT_BIT) begin
                    cnt_d   = '0;
                    shift_d = {shift_q[9:0], rx_s_q};
                    idx_d   = idx_q + 4'd1;
                    if (idx_q == 4'd10) begin
                        state_d = PARADA;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARADA: begin
                if (cnt_q == CNT_BIT) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        erro_d  = 1'b1;
                        state_d = ESPERA;
                    end else if (end_ok) begin
                        pacote_d = shift_q;
                        valido_d = 1'b1;
                        state_d  = OCIOSO;
                    end else begin
                        desc_d  = 1'b1;
                        state_d = OCIOSO;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ESPERA: begin
                if (rx_s_q) begin
                    state_d = OCIOSO;
                    cnt_d   = '0;
                end
            end
            default: state_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= 1'b1;
            rx_s_q   <= 1'b1;
            state_q  <= OCIOSO;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            pacote_q <= '0;
            valido_q <= 1'b0;
            erro_q   <= 1'b0;
            desc_q   <= 1'b0;
        end else begin
            sync_q   <= serial_in;
            rx_s_q   <= sync_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            pacote_q <= pacote_d;
            valido_q <= valido_d;
            erro_q   <= erro_d;
            desc_q   <= desc_d;
        end
    end

    assign pacote      = pacote_q;
    assign endereco    = pacote_q[10:8];
    assign dados       = pacote_q[7:0];
    assign valido      = valido_q;
    assign erro_quadro = erro_q;
    assign descartado  = desc_q;
    assign ocupado     = (state_q != OCIOSO);

endmodule
